// File: rtl/mac_pe_feeder.sv
// mac_pe_feeder: sequences one dot product through an external MAC processing
// element. Operand chunks are taken from two streams with a joint handshake,
// forwarded to the PE one cycle later, and after the PE pipeline drains the
// accumulator value is presented on a valid/ready result port.
module mac_pe_feeder #(
    parameter int InDataWidth  = 8,
    parameter int NumInputs    = 4,
    parameter int OutDataWidth = 32,
    parameter int CntWidth     = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [CntWidth-1:0]              k_chunks_i,
    input  logic                             abort_i,
    input  logic [NumInputs*InDataWidth-1:0] a_data_i,
    input  logic [NumInputs*InDataWidth-1:0] b_data_i,
    input  logic                             a_valid_i,
    input  logic                             b_valid_i,
    output logic                             a_ready_o,
    output logic                             b_ready_o,
    output logic [NumInputs*InDataWidth-1:0] pe_a_o,
    output logic [NumInputs*InDataWidth-1:0] pe_b_o,
    output logic                             pe_a_valid_o,
    output logic                             pe_b_valid_o,
    output logic                             pe_init_save_o,
    output logic                             pe_acc_clr_o,
    input  logic [OutDataWidth-1:0]          pe_c_i,
    output logic [OutDataWidth-1:0]          res_o,
    output logic                             res_valid_o,
    input  logic                             res_ready_i,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int VecWidth = NumInputs * InDataWidth;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Control state
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] k_q;
    logic                wait_q;

    // Stage 1: operands and flags handed to the PE
    logic signed [VecWidth-1:0] pe_a_p1;
    logic signed [VecWidth-1:0] pe_b_p1;
    logic                       vld_p1;
    logic                       init_save_p1;
    logic                       acc_clr_p1;
    logic                       done_p1;

    // Result captured from the PE after the drain period
    logic signed [OutDataWidth-1:0] res_p1;

    logic accept;
    logic last_chunk;
    logic start_run;
    logic start_zero;
    logic out_hs;
    logic wait_end;

    // A chunk is consumed only when both operand streams are valid together.
    assign accept     = (state_q == FEED) & a_valid_i & b_valid_i;
    assign last_chunk = (cnt_q == (k_q - CntWidth'(1)));
    assign start_run  = (state_q == IDLE) & start_i & (k_chunks_i != '0);
    assign start_zero = (state_q == IDLE) & start_i & (k_chunks_i == '0);
    assign out_hs     = (state_q == OUT) & res_ready_i;
    assign wait_end   = (state_q == WAIT) & wait_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_run) begin
                    state_d = FEED;
                end else if (start_zero) begin
                    state_d = OUT;
                end
            end
            FEED: begin
                if (accept && last_chunk) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
        end
    end

    // Chunk counter and latched chunk count; counter saturates at the last chunk
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            k_q   <= '0;
        end else if (abort_i) begin
            cnt_q <= '0;
        end else if (start_run) begin
            cnt_q <= '0;
            k_q   <= k_chunks_i;
        end else if (accept && !last_chunk) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    // Two-cycle drain timer covering the PE register stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= 1'b0;
        end else if (abort_i || state_q != WAIT) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= ~wait_q;
        end
    end

    // Operand registers toward the PE; hold their value between chunks
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pe_a_p1 <= '0;
            pe_b_p1 <= '0;
        end else if (accept) begin
            pe_a_p1 <= a_data_i;
            pe_b_p1 <= b_data_i;
        end
    end

    // PE strobes: valid per accepted chunk, init_save on the first chunk only
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1       <= 1'b0;
            init_save_p1 <= 1'b0;
        end else begin
            vld_p1       <= accept & ~abort_i;
            init_save_p1 <= accept & ~abort_i & (cnt_q == '0);
        end
    end

    // One-cycle accumulator clear on abort or on an empty dot product
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_clr_p1 <= 1'b0;
        end else begin
            acc_clr_p1 <= abort_i | start_zero;
        end
    end

    // Result capture: zero for an empty run, PE accumulator at end of drain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_p1 <= '0;
        end else if (!abort_i) begin
            if (start_zero) begin
                res_p1 <= '0;
            end else if (wait_end) begin
                res_p1 <= pe_c_i;
            end
        end
    end

    // Completion pulse in the cycle after the result handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_p1 <= 1'b0;
        end else begin
            done_p1 <= out_hs & ~abort_i;
        end
    end

    assign a_ready_o      = accept;
    assign b_ready_o      = accept;
    assign pe_a_o         = pe_a_p1;
    assign pe_b_o         = pe_b_p1;
    assign pe_a_valid_o   = vld_p1;
    assign pe_b_valid_o   = vld_p1;
    assign pe_init_save_o = init_save_p1;
    assign pe_acc_clr_o   = acc_clr_p1;
    assign res_o          = res_p1;
    assign res_valid_o    = (state_q == OUT);
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_p1;

endmodule

// File: doc/mac_pe_feeder.md
MAC_PE_FEEDER -- requirements
Module: mac_pe_feeder

Interface
REQ-001 Parameters SHALL be: InDataWidth, default 8, operand element width; NumInputs, default 4, elements per chunk; OutDataWidth, default 32, accumulator/result width; CntWidth, default 16, chunk-count width.
REQ-002 There SHALL be one clock, and the reset SHALL be asynchronous and active-low. The ports SHALL be:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start one dot product; sampled in IDLE only
- k_chunks_i  in  CntWidth  number of NumInputs-wide chunks per dot product; latched on start
- abort_i  in  1  synchronous abort
- a_data_i / b_data_i  in  NumInputs*InDataWidth  signed operand chunks, packed
- a_valid_i / b_valid_i  in  1  operand valid
- a_ready_o / b_ready_o  out  1  operand ready
- pe_a_o / pe_b_o  out  NumInputs*InDataWidth  operands to the PE
- pe_a_valid_o / pe_b_valid_o  out  1  PE operand valid
- pe_init_save_o  out  1  PE loads the dot product instead of accumulating
- pe_acc_clr_o  out  1  PE accumulator clear
- pe_c_i  in  OutDataWidth  signed PE accumulator output
- res_o  out  OutDataWidth  signed result
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle completion pulse

Function
REQ-003 PE contract: the PE registers the result; pe_c_i reflects a valid chunk one cycle after that chunk's pe_*_valid_o cycle.
REQ-004 The FSM states SHALL be IDLE, FEED, WAIT and OUT.
REQ-005 IDLE: start_i=1 with k_chunks_i>0 SHALL latch k_chunks_i, clear the chunk counter, and go to FEED.
REQ-006 IDLE: start_i=1 with k_chunks_i=0 SHALL:
- pulse pe_acc_clr_o for 1 cycle;
- load res_o=0;
- go to OUT.
REQ-007 start_i SHALL be ignored in every state other than IDLE.
REQ-008 FEED handshake: a_ready_o = b_ready_o = (state==FEED) & a_valid_i & b_valid_i. This is a joint handshake: no chunk is consumed unless both operands are valid.
REQ-009 On each accepted chunk, the next cycle SHALL have:
- pe_a_o/pe_b_o = the accepted data;
- pe_a_valid_o = pe_b_valid_o = 1;
- pe_init_save_o = 1 only for chunk 0.
REQ-010 In cycles with no accepted chunk: pe_*_valid_o=0 and pe_init_save_o=0; pe_a_o/pe_b_o SHALL hold their last values.
REQ-011 Acceptance of chunk k_chunks-1 SHALL move the FSM to WAIT. The counter SHALL never exceed k_chunks-1 and SHALL not wrap.
REQ-012 WAIT SHALL last exactly 2 cycles. At the end of the second cycle, res_o <= pe_c_i and the FSM goes to OUT.
REQ-013 Latency: last chunk accepted in cycle t -> pe valid in t+1 -> pe_c_i valid in t+2 -> res_valid_o=1 from t+3.
REQ-014 OUT: res_valid_o=1 and res_o SHALL be held stable until res_valid_o & res_ready_i.
REQ-015 On the OUT handshake: done_o=1 for the next cycle, and the FSM returns to IDLE. A new start is accepted in the cycle after done.
REQ-016 abort_i SHALL take priority in any state. The next cycle SHALL have:
- FSM in IDLE;
- pe_*_valid_o=0 and res_valid_o=0;
- pe_acc_clr_o=1 for 1 cycle;
- no done_o.
REQ-017 abort_i in IDLE SHALL only pulse pe_acc_clr_o.
REQ-018 The block SHALL perform no arithmetic: the result is pe_c_i passed through unmodified at OutDataWidth; overflow is the PE's responsibility.
REQ-019 busy_o SHALL be 1 exactly when state != IDLE.

Reset
REQ-020 While rst_ni=0, and at once, the following SHALL hold:
- state=IDLE and counter=0;
- all valid, ready, init_save and done outputs = 0;
- busy_o=0;
- pe_acc_clr_o=0;
- pe_a_o, pe_b_o and res_o = 0.
REQ-021 Reset asserted mid-operation SHALL discard the operation; after release, the block SHALL wait in IDLE for start_i.

Verification
REQ-022 k=1, a={1,2,3,4}, b={5,6,7,8} accepted in cycle t -> pe_init_save_o=1 in t+1; res_o=70 with res_valid_o=1 in t+3.
REQ-023 k=3, every element -128 x -128, a_valid_i/b_valid_i toggled with 2-cycle gaps -> exactly 3 chunks issued, init_save on the first only; res_o=196608.
REQ-024 Back-pressure: res_ready_i=0 for 5 cycles in OUT -> res_o/res_valid_o stable; done_o pulses once, 1 cycle after ready rises.
REQ-025 k_chunks_i=0 start -> pe_acc_clr_o pulse; res_o=0, res_valid_o=1; no pe_*_valid_o ever asserted.
REQ-026 abort_i after 2 of 4 chunks -> IDLE next cycle with pe_acc_clr_o=1 and no done_o; a fresh k=1 run then returns the correct result.
REQ-027 rst_ni dropped in WAIT -> all outputs 0 immediately; start_i during the OUT state of a later run is ignored.
